// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types, FSM state encoding and legal byte-enable patterns
//               for the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] BE_LANE0   = 4'b0001;
    localparam logic [3:0] BE_LANE1   = 4'b0010;
    localparam logic [3:0] BE_LANE2   = 4'b0100;
    localparam logic [3:0] BE_LANE3   = 4'b1000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Core request, bus command/response and core response signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
    import mem_access_pkg::*;

    logic       req_valid;
    logic       req_write;
    addr_t      req_addr;
    logic [3:0] req_byte_en;
    data_t      req_wdata;
    logic       req_ready;

    logic       bus_valid;
    logic       bus_write;
    addr_t      bus_addr;
    logic [3:0] bus_be;
    data_t      bus_wdata;
    logic       bus_ready;
    logic       bus_rsp_valid;
    data_t      bus_rdata;

    logic       rsp_valid;
    data_t      rsp_rdata;
    addr_t      rsp_addr;
    logic       rsp_error;
    logic       busy;

    // The unit itself: serves core requests and masters the memory bus.
    modport slave (
        input  req_valid, req_write, req_addr, req_byte_en, req_wdata,
        output req_ready,
        output bus_valid, bus_write, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rsp_valid, bus_rdata,
        output rsp_valid, rsp_rdata, rsp_addr, rsp_error, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_byte_en, req_wdata,
        input  req_ready,
        input  bus_valid, bus_write, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rsp_valid, bus_rdata,
        input  rsp_valid, rsp_rdata, rsp_addr, rsp_error, busy
    );

endinterface

`default_nettype wire

// File: rtl/mem_access_unit_be_check.sv
// ============================================================================
// Module      : mem_be_check
// Description : Combinational legality check of byte enables against the
//               byte offset of the access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_be_check
    import mem_access_pkg::*;
(
    input  wire logic [1:0] addr_i,
    input  wire logic [3:0] byte_en_i,
    output logic            legal_o
);

    always_comb begin
        legal_o = 1'b0;
        case (byte_en_i)
            BE_LANE0:   legal_o = (addr_i == 2'd0);
            BE_LANE1:   legal_o = (addr_i == 2'd1);
            BE_LANE2:   legal_o = (addr_i == 2'd2);
            BE_LANE3:   legal_o = (addr_i == 2'd3);
            BE_HALF_LO: legal_o = (addr_i == 2'd0);
            BE_HALF_HI: legal_o = (addr_i == 2'd2);
            BE_WORD:    legal_o = (addr_i == 2'd0);
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store bridge from the core to a
//               word-addressed bus with response timeout and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  wire logic       clk,
    input  wire logic       reset,
    mem_access_unit_if.slave mif
);

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        req_ready_q;
    logic        busy_q;
    logic        bus_valid_q;
    logic        bus_write_q;
    addr_t       bus_addr_q;
    logic [3:0]  bus_be_q;
    data_t       bus_wdata_q;
    logic        rsp_valid_q;
    data_t       rsp_rdata_q;
    addr_t       rsp_addr_q;
    logic        rsp_error_q;
    logic        w_be_legal;

    mem_be_check u_be_check (
        .addr_i    (mif.req_addr[1:0]),
        .byte_en_i (mif.req_byte_en),
        .legal_o   (w_be_legal)
    );

    assign mif.req_ready = req_ready_q;
    assign mif.busy      = busy_q;
    assign mif.bus_valid = bus_valid_q;
    assign mif.bus_write = bus_write_q;
    assign mif.bus_addr  = bus_addr_q;
    assign mif.bus_be    = bus_be_q;
    assign mif.bus_wdata = bus_wdata_q;
    assign mif.rsp_valid = rsp_valid_q;
    assign mif.rsp_rdata = rsp_rdata_q;
    assign mif.rsp_addr  = rsp_addr_q;
    assign mif.rsp_error = rsp_error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mif.req_valid) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_addr_q  <= mif.req_addr;
                        bus_write_q <= mif.req_write;
                        bus_addr_q  <= {mif.req_addr[31:2], 2'b00};
                        bus_be_q    <= mif.req_byte_en;
                        bus_wdata_q <= mif.req_wdata;
                        if (w_be_legal) begin
                            state_q     <= ST_ISSUE;
                            bus_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mif.bus_ready) begin
                        bus_valid_q <= 1'b0;
                        cnt_q       <= 16'd0;
                        // A response in the handshake cycle itself skips WAIT.
                        if (mif.bus_rsp_valid) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b0;
                            rsp_rdata_q <= bus_write_q ? '0 : mif.bus_rdata;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mif.bus_rsp_valid) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= bus_write_q ? '0 : mif.bus_rdata;
                    end else if (cnt_q == c_TIMEOUT_LAST) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    cnt_q       <= 16'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_access_unit_if bus_if ();

    mem_access_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        bus_if.req_valid   = 1'b1;
        bus_if.req_write   = wr;
        bus_if.req_addr    = addr;
        bus_if.req_byte_en = be;
        bus_if.req_wdata   = wdata;
    endtask

    task automatic clear_req();
        bus_if.req_valid   = 1'b0;
        bus_if.req_write   = 1'b0;
        bus_if.req_addr    = 32'h0;
        bus_if.req_byte_en = 4'h0;
        bus_if.req_wdata   = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        clear_req();
        bus_if.bus_ready     = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rdata     = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rst_busy",      32'(bus_if.busy),      32'd0);
        chk("rst_bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_error", 32'(bus_if.rsp_error), 32'd0);
        reset = 1'b0;
        tick();

        // Word load, minimum latency
        request(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
        tick();
        clear_req();
        chk("ld_bus_valid", 32'(bus_if.bus_valid), 32'd1);
        chk("ld_bus_addr",  bus_if.bus_addr,       32'h0000_0100);
        chk("ld_bus_be",    32'(bus_if.bus_be),    32'hF);
        chk("ld_bus_write", 32'(bus_if.bus_write), 32'd0);
        chk("ld_req_ready", 32'(bus_if.req_ready), 32'd0);
        chk("ld_busy",      32'(bus_if.busy),      32'd1);
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready     = 1'b0;
        chk("ld_wait_bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("ld_wait_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rdata     = 32'hDEAD_BEEF;
        tick();
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rdata     = 32'h0;
        chk("ld_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("ld_rsp_rdata", bus_if.rsp_rdata,      32'hDEAD_BEEF);
        chk("ld_rsp_addr",  bus_if.rsp_addr,       32'h0000_0100);
        chk("ld_rsp_error", 32'(bus_if.rsp_error), 32'd0);
        tick();
        chk("ld_done_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("ld_done_req_ready", 32'(bus_if.req_ready), 32'd1);

        // Byte store, bus_ready stalled 5 cycles, stray response ignored
        request(1'b1, 32'h0000_0203, 4'b1000, 32'hAB00_0000);
        tick();
        clear_req();
        for (int i = 0; i < 5; i++) begin
            bus_if.bus_rsp_valid = (i == 2);
            bus_if.bus_rdata     = 32'h1111_2222;
            chk("st_hold_valid", 32'(bus_if.bus_valid), 32'd1);
            chk("st_hold_addr",  bus_if.bus_addr,       32'h0000_0200);
            chk("st_hold_be",    32'(bus_if.bus_be),    32'h8);
            chk("st_hold_wdata", bus_if.bus_wdata,      32'hAB00_0000);
            chk("st_hold_write", 32'(bus_if.bus_write), 32'd1);
            chk("st_hold_ready", 32'(bus_if.req_ready), 32'd0);
            tick();
        end
        chk("st_stray_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.bus_ready     = 1'b1;
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rdata     = 32'h1234_5678;
        tick();
        bus_if.bus_ready     = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rdata     = 32'h0;
        chk("st_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("st_rsp_rdata", bus_if.rsp_rdata,      32'h0);
        chk("st_rsp_addr",  bus_if.rsp_addr,       32'h0000_0203);
        chk("st_rsp_error", 32'(bus_if.rsp_error), 32'd0);
        tick();

        // Illegal enables, then a legal request held through RESP
        request(1'b0, 32'h0000_0101, 4'b0011, 32'h0);
        tick();
        request(1'b0, 32'h0000_0104, 4'b1111, 32'h0);
        chk("ill_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("ill_rsp_error", 32'(bus_if.rsp_error), 32'd1);
        chk("ill_bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("ill_rsp_addr",  bus_if.rsp_addr,       32'h0000_0101);
        chk("ill_req_ready", 32'(bus_if.req_ready), 32'd0);
        tick();
        chk("b2b_idle_ready", 32'(bus_if.req_ready), 32'd1);
        chk("b2b_idle_bus",   32'(bus_if.bus_valid), 32'd0);
        tick();
        clear_req();
        chk("b2b_bus_valid", 32'(bus_if.bus_valid), 32'd1);
        chk("b2b_bus_addr",  bus_if.bus_addr,       32'h0000_0104);
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready     = 1'b0;
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rdata     = 32'h55AA_55AA;
        tick();
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rdata     = 32'h0;
        chk("b2b_rsp_rdata", bus_if.rsp_rdata,      32'h55AA_55AA);
        chk("b2b_rsp_error", 32'(bus_if.rsp_error), 32'd0);
        tick();

        // Timeout with TIMEOUT_CYCLES=4
        request(1'b0, 32'h0000_0108, 4'b1111, 32'h0);
        tick();
        clear_req();
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            chk("to_wait_busy",      32'(bus_if.busy),      32'd1);
            tick();
        end
        chk("to_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("to_rsp_error", 32'(bus_if.rsp_error), 32'd1);
        chk("to_rsp_rdata", bus_if.rsp_rdata,      32'h0);
        chk("to_rsp_addr",  bus_if.rsp_addr,       32'h0000_0108);
        tick();
        chk("to_idle_ready", 32'(bus_if.req_ready), 32'd1);
        chk("to_idle_busy",  32'(bus_if.busy),      32'd0);

        // Reset during ISSUE drops bus_valid asynchronously
        request(1'b0, 32'h0000_010C, 4'b1111, 32'h0);
        tick();
        clear_req();
        chk("rsti_bus_valid_pre", 32'(bus_if.bus_valid), 32'd1);
        reset = 1'b1;
        #2;
        chk("rsti_bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rsti_req_ready", 32'(bus_if.req_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // Reset during WAIT, late response after release ignored
        request(1'b0, 32'h0000_0110, 4'b1111, 32'h0);
        tick();
        clear_req();
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        chk("rstw_busy_pre", 32'(bus_if.busy), 32'd1);
        reset = 1'b1;
        #2;
        chk("rstw_busy", 32'(bus_if.busy), 32'd0);
        tick();
        reset = 1'b0;
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rdata     = 32'h9999_9999;
        tick();
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rdata     = 32'h0;
        chk("rstw_rsp_valid",  32'(bus_if.rsp_valid), 32'd0);
        chk("rstw_req_ready",  32'(bus_if.req_ready), 32'd1);
        tick();
        chk("rstw_rsp_valid2", 32'(bus_if.rsp_valid), 32'd0);
        chk("rstw_rsp_rdata",  bus_if.rsp_rdata,      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
